mem_access_unit: RTL

MEM pipeline stage for the MIPS core: takes the instruction held in the EX/MEM register, runs loads/stores on the SRAM-like data bus through a small handshake FSM, detects address-error exceptions, and presents result, destination and PC to the MEM/WB register. It raises a stall request while an access is outstanding and discards results of transactions cancelled by a flush.

---
 rtl/cpu_defs_pkg.sv | 56 +++++
 rtl/load_align.sv | 32 +++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: memory op encodings, bus size codes, MEM-stage FSM
// states and the latched bus request record.
package cpu_defs_pkg;

  localparam int XLEN = 32;
  localparam int DLEN = 64;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    mem_op_t           op;
    logic              wr;
    logic [1:0]        size;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } bus_req_t;

  function automatic logic op_is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic op_is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [1:0] op_size(mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SIZE_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SIZE_HALF;
      MEM_LW, MEM_SW:          return SIZE_WORD;
      default:                 return SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane select and sign/zero extension of a 32-bit read word.
module load_align
  import cpu_defs_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    case (off_i)
      2'd0:    byte_l = rdata_i[7:0];
      2'd1:    byte_l = rdata_i[15:8];
      2'd2:    byte_l = rdata_i[23:16];
      default: byte_l = rdata_i[31:24];
    endcase
    half_l = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      MEM_LB:  result_o = {{24{byte_l[7]}}, byte_l};
      MEM_LBU: result_o = {24'b0, byte_l};
      MEM_LH:  result_o = {{16{half_l[15]}}, half_l};
      MEM_LHU: result_o = {16'b0, half_l};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: drives loads/stores over the SRAM-like handshake bus,
// flags address errors and hands result/dest/PC to MEM/WB.
module mem_access_unit
  import cpu_defs_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  mem_op_t         mem_op_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_sdata_i,
  input  logic [4:0]      mem_wd_i,
  input  logic            mem_wreg_i,
  input  logic [DLEN-1:0] mem_wdata_i,
  input  logic [XLEN-1:0] mem_pc_i,
  output logic            data_req_o,
  output logic            data_wr_o,
  output logic [1:0]      data_size_o,
  output logic [XLEN-1:0] data_addr_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic            data_addr_ok_i,
  input  logic            data_data_ok_i,
  input  logic [XLEN-1:0] data_rdata_i,
  output logic [4:0]      mem_wd_o,
  output logic            mem_wreg_o,
  output logic [DLEN-1:0] mem_wdata_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [XLEN-1:0] mem_bad_addr_o,
  output logic            adel_o,
  output logic            ades_o,
  output logic            stallreq_o
);

  mem_state_t      state_q, state_d;
  logic            cancel_q, cancel_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  bus_req_t        breq_q, breq_d, breq_in;

  logic            is_load, is_store, is_mem;
  logic            misaligned, exc, issue;
  logic [XLEN-1:0] load_res;

  // Decode of the instruction currently sitting in EX/MEM
  always_comb begin
    is_load  = op_is_load(mem_op_i);
    is_store = op_is_store(mem_op_i);
    is_mem   = is_load | is_store;
    case (op_size(mem_op_i))
      SIZE_HALF: misaligned = mem_addr_i[0];
      SIZE_WORD: misaligned = |mem_addr_i[1:0];
      default:   misaligned = 1'b0;
    endcase
    exc   = is_mem & misaligned;
    issue = (state_q == ST_IDLE) & is_mem & ~exc & ~flush_i;

    breq_in.op   = mem_op_i;
    breq_in.wr   = is_store;
    breq_in.size = op_size(mem_op_i);
    breq_in.addr = mem_addr_i;
    case (mem_op_i)
      MEM_SB:  breq_in.wdata = {4{mem_sdata_i[7:0]}};
      MEM_SH:  breq_in.wdata = {2{mem_sdata_i[15:0]}};
      default: breq_in.wdata = mem_sdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
      breq_q   <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      breq_q   <= breq_d;
    end
  end

  // Once issued, a request always runs to data_ok; a flush only marks it
  // cancelled so its data never reaches MEM/WB.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    breq_d   = breq_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          breq_d  = breq_in;
          state_d = data_addr_ok_i ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flush_i)        cancel_d = 1'b1;
        if (data_addr_ok_i) state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (data_data_ok_i) begin
          if (cancel_q | flush_i) begin
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            rdata_d = data_rdata_i;
            state_d = ST_DONE;
          end
        end else if (flush_i) begin
          cancel_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .op_i     (breq_q.op),
    .off_i    (breq_q.addr[1:0]),
    .rdata_i  (rdata_q),
    .result_o (load_res)
  );

  // Bus fields come straight from EX/MEM while issuing, then from the
  // latched copy so they stay stable until the address is accepted.
  always_comb begin
    data_req_o   = issue | (state_q == ST_ADDR);
    data_wr_o    = (state_q == ST_IDLE) ? breq_in.wr    : breq_q.wr;
    data_size_o  = (state_q == ST_IDLE) ? breq_in.size  : breq_q.size;
    data_addr_o  = (state_q == ST_IDLE) ? breq_in.addr  : breq_q.addr;
    data_wdata_o = (state_q == ST_IDLE) ? breq_in.wdata : breq_q.wdata;
    stallreq_o   = issue | (state_q == ST_ADDR) | (state_q == ST_DATA);

    mem_wd_o    = mem_wd_i;
    mem_pc_o    = mem_pc_i;
    mem_wreg_o  = mem_wreg_i & ~exc & ~cancel_q;
    mem_wdata_o = ((state_q == ST_DONE) && !breq_q.wr) ? {32'b0, load_res}
                                                       : mem_wdata_i;

    adel_o         = exc & is_load;
    ades_o         = exc & is_store;
    mem_bad_addr_o = exc ? mem_addr_i : '0;
  end

endmodule
